// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_if
// Brief    : Byte-source, RAM-write and CPU-control signals of prog_loader.
// Revision : 1.0 - initial release
// ============================================================================
interface prog_loader_if;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       we;
  logic [7:0] w_addr;
  logic [7:0] w_data;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, we, w_addr, w_data, cpu_reset, busy, done, err
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, we, w_addr, w_data, cpu_reset, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : Streams PROG_LEN bytes into program RAM while holding the CPU in
//            reset. Define LOADER_CHECKSUM_EN to add a trailing checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int unsigned PROG_LEN  = 16,
  parameter logic [7:0]  BASE_ADDR = 8'h00
) (
  input wire           clk,
  input wire           reset,
  prog_loader_if.slave bus
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_LOAD    = 2'd1;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [1:0] c_CHECK   = 2'd2;
`endif
  localparam logic [1:0] c_RELEASE = 2'd3;
  localparam logic [7:0] c_LAST    = 8'(PROG_LEN - 1);

  logic [1:0] r_state,     w_nx_state;
  logic [7:0] r_index,     w_nx_index;
  logic       r_rel_cnt,   w_nx_rel_cnt;
  logic       r_in_ready,  w_nx_in_ready;
  logic       r_we,        w_nx_we;
  logic [7:0] r_w_addr,    w_nx_w_addr;
  logic [7:0] r_w_data,    w_nx_w_data;
  logic       r_cpu_reset, w_nx_cpu_reset;
  logic       r_busy,      w_nx_busy;
  logic       r_done,      w_nx_done;
  logic       w_beat;
  logic       w_last;

  assign w_beat = bus.in_valid & r_in_ready;
  assign w_last = (r_index == c_LAST);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_sum, w_nx_sum;
  logic       r_err, w_nx_err;
  logic [7:0] w_sum_chk;
  logic       w_sum_ok;

  assign w_sum_chk = r_sum + bus.in_data;
  assign w_sum_ok  = (w_sum_chk == 8'h00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum <= 8'h00;
      r_err <= 1'b0;
    end else begin
      r_sum <= w_nx_sum;
      r_err <= w_nx_err;
    end
  end
`endif

  // State register; every output is registered alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_IDLE;
      r_index     <= 8'h00;
      r_rel_cnt   <= 1'b0;
      r_in_ready  <= 1'b0;
      r_we        <= 1'b0;
      r_w_addr    <= 8'h00;
      r_w_data    <= 8'h00;
      r_cpu_reset <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_nx_state;
      r_index     <= w_nx_index;
      r_rel_cnt   <= w_nx_rel_cnt;
      r_in_ready  <= w_nx_in_ready;
      r_we        <= w_nx_we;
      r_w_addr    <= w_nx_w_addr;
      r_w_data    <= w_nx_w_data;
      r_cpu_reset <= w_nx_cpu_reset;
      r_busy      <= w_nx_busy;
      r_done      <= w_nx_done;
    end
  end

  always_comb begin
    w_nx_state = r_state;
    case (r_state)
      c_IDLE: if (bus.start) w_nx_state = c_LOAD;
      c_LOAD: begin
        if (w_beat && w_last) begin
`ifdef LOADER_CHECKSUM_EN
          w_nx_state = c_CHECK;
`else
          w_nx_state = c_RELEASE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      c_CHECK: if (w_beat) w_nx_state = w_sum_ok ? c_RELEASE : c_IDLE;
`endif
      c_RELEASE: if (r_rel_cnt) w_nx_state = c_IDLE;
      default: w_nx_state = c_IDLE;
    endcase
  end

  always_comb begin
    w_nx_in_ready  = 1'b0;
    w_nx_we        = 1'b0;
    w_nx_w_addr    = r_w_addr;
    w_nx_w_data    = r_w_data;
    w_nx_cpu_reset = r_cpu_reset;
    w_nx_busy      = r_busy;
    w_nx_done      = 1'b0;
    w_nx_index     = r_index;
    w_nx_rel_cnt   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    w_nx_sum       = r_sum;
    w_nx_err       = r_err;
`endif
    case (r_state)
      c_IDLE: begin
        w_nx_busy = 1'b0;
        // A failed checksum keeps the CPU parked until a good load lands.
`ifdef LOADER_CHECKSUM_EN
        w_nx_cpu_reset = ~r_err;
`else
        w_nx_cpu_reset = 1'b1;
`endif
        if (bus.start) begin
          w_nx_in_ready  = 1'b1;
          w_nx_busy      = 1'b1;
          w_nx_cpu_reset = 1'b0;
          w_nx_index     = 8'h00;
`ifdef LOADER_CHECKSUM_EN
          w_nx_sum       = 8'h00;
          w_nx_err       = 1'b0;
`endif
        end
      end
      c_LOAD: begin
        w_nx_in_ready = 1'b1;
        if (w_beat) begin
          w_nx_we     = 1'b1;
          w_nx_w_addr = BASE_ADDR + r_index;
          w_nx_w_data = bus.in_data;
          w_nx_index  = r_index + 8'd1;
`ifdef LOADER_CHECKSUM_EN
          w_nx_sum    = w_sum_chk;
`else
          if (w_last) w_nx_in_ready = 1'b0;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      c_CHECK: begin
        w_nx_in_ready = 1'b1;
        if (w_beat) begin
          w_nx_in_ready = 1'b0;
          if (!w_sum_ok) begin
            w_nx_err  = 1'b1;
            w_nx_busy = 1'b0;
          end
        end
      end
`endif
      c_RELEASE: begin
        // Two cycles in reset so the final RAM write settles first.
        w_nx_rel_cnt = ~r_rel_cnt;
        if (r_rel_cnt) begin
          w_nx_done      = 1'b1;
          w_nx_cpu_reset = 1'b1;
          w_nx_busy      = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.we        = r_we;
  assign bus.w_addr    = r_w_addr;
  assign bus.w_data    = r_w_data;
  assign bus.cpu_reset = r_cpu_reset;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
`ifdef LOADER_CHECKSUM_EN
  assign bus.err       = r_err;
`else
  assign bus.err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Brief    : Randomised bench for prog_loader against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;
  localparam int         c_LEN0  = 16;
  localparam logic [7:0] c_BASE0 = 8'h00;
  localparam int         c_LEN1  = 4;
  localparam logic [7:0] c_BASE1 = 8'hFE;
`ifdef LOADER_CHECKSUM_EN
  localparam bit c_CS = 1'b1;
`else
  localparam bit c_CS = 1'b0;
`endif
  localparam int c_P_IDLE = 0, c_P_LOAD = 1, c_P_CHECK = 2, c_P_REL = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if bus0 ();
  prog_loader_if bus1 ();

  prog_loader #(.PROG_LEN(c_LEN0), .BASE_ADDR(c_BASE0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  prog_loader #(.PROG_LEN(c_LEN1), .BASE_ADDR(c_BASE1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic [1:0] s_start = 2'b00;
  logic [1:0] s_valid = 2'b00;
  logic [7:0] s_data [2];
  logic [1:0] o_in_ready, o_we, o_cpu_reset, o_busy, o_done, o_err;
  logic [7:0] o_addr [2];
  logic [7:0] o_data [2];

  assign bus0.start = s_start[0];  assign bus1.start = s_start[1];
  assign bus0.in_valid = s_valid[0];  assign bus1.in_valid = s_valid[1];
  assign bus0.in_data = s_data[0];  assign bus1.in_data = s_data[1];
  assign o_in_ready  = {bus1.in_ready, bus0.in_ready};
  assign o_we        = {bus1.we, bus0.we};
  assign o_cpu_reset = {bus1.cpu_reset, bus0.cpu_reset};
  assign o_busy      = {bus1.busy, bus0.busy};
  assign o_done      = {bus1.done, bus0.done};
  assign o_err       = {bus1.err, bus0.err};
  assign o_addr[0] = bus0.w_addr;  assign o_addr[1] = bus1.w_addr;
  assign o_data[0] = bus0.w_data;  assign o_data[1] = bus1.w_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_beat = 0;
  int done_cnt [2];
  int done_cyc [2];
  logic [7:0] ram [2][256];
  logic [7:0] wq0 [$];
  logic [7:0] wq1 [$];
  logic [7:0] prog [$];

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (dut%0d): got 0x%0h, expected 0x%0h at cycle %0d", name, d, act, exp, cyc);
    end
  endtask

  // Expected outputs after each clock, derived from the loader's rules.
  typedef struct {
    int phase; int idx; int sum; int rel;
    bit in_ready; bit we; bit cpu_reset; bit busy; bit done; bit err;
    bit [7:0] addr; bit [7:0] data;
  } model_t;
  model_t m [2];

  function automatic model_t model_zero();
    model_t z;
    z.phase = c_P_IDLE; z.idx = 0; z.sum = 0; z.rel = 0;
    z.in_ready = 0; z.we = 0; z.cpu_reset = 0; z.busy = 0; z.done = 0; z.err = 0;
    z.addr = 8'h00; z.data = 8'h00;
    return z;
  endfunction

  function automatic model_t step(model_t mi, int d, logic st, logic v, logic [7:0] dt);
    model_t n;
    int len, base;
    n = mi; n.we = 1'b0; n.done = 1'b0;
    len  = (d == 0) ? c_LEN0 : c_LEN1;
    base = (d == 0) ? int'(c_BASE0) : int'(c_BASE1);
    case (mi.phase)
      c_P_IDLE: begin
        n.cpu_reset = !mi.err;
        if (st) begin
          n.phase = c_P_LOAD; n.idx = 0; n.sum = 0; n.err = 1'b0;
          n.in_ready = 1'b1; n.busy = 1'b1; n.cpu_reset = 1'b0;
        end
      end
      c_P_LOAD: if (v && mi.in_ready) begin
        n.we = 1'b1; n.addr = 8'((base + mi.idx) % 256); n.data = dt;
        n.idx = mi.idx + 1; n.sum = (mi.sum + int'(dt)) % 256;
        if (n.idx == len) begin
          if (c_CS) n.phase = c_P_CHECK;
          else begin n.phase = c_P_REL; n.rel = 2; n.in_ready = 1'b0; end
        end
      end
      c_P_CHECK: if (v && mi.in_ready) begin
        n.in_ready = 1'b0;
        if ((mi.sum + int'(dt)) % 256 == 0) begin n.phase = c_P_REL; n.rel = 2; end
        else begin n.err = 1'b1; n.busy = 1'b0; n.phase = c_P_IDLE; end
      end
      default: begin
        if (mi.rel == 1) begin
          n.done = 1'b1; n.cpu_reset = 1'b1; n.busy = 1'b0; n.phase = c_P_IDLE;
        end else n.rel = mi.rel - 1;
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m[0] <= model_zero();
      m[1] <= model_zero();
    end else begin
      m[0] <= step(m[0], 0, s_start[0], s_valid[0], s_data[0]);
      m[1] <= step(m[1], 1, s_start[1], s_valid[1], s_data[1]);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle comparison, plus RAM / write-log / done capture.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check("in_ready", d, o_in_ready[d], m[d].in_ready);
      check("we", d, o_we[d], m[d].we);
      check("cpu_reset", d, o_cpu_reset[d], m[d].cpu_reset);
      check("busy", d, o_busy[d], m[d].busy);
      check("done", d, o_done[d], m[d].done);
      check("err", d, o_err[d], m[d].err);
      if (m[d].we) begin
        check("w_addr", d, o_addr[d], m[d].addr);
        check("w_data", d, o_data[d], m[d].data);
      end
      if (o_we[d] === 1'b1) begin
        ram[d][o_addr[d]] = o_data[d];
        if (d == 0) wq0.push_back(o_addr[d]); else wq1.push_back(o_addr[d]);
      end
      if (o_done[d] === 1'b1) begin
        done_cnt[d]++;
        done_cyc[d] = cyc;
      end
    end
  end

  task automatic run_load(input int d, input int gap_at, input int gap_len, input bit rnd,
                          input bit cs_bad, input int abort_at);
    int n, total, k, gap, budget;
    logic [7:0] cs, sum;
    bit v;
    n = prog.size(); sum = 8'h00;
    foreach (prog[i]) sum += prog[i];
    cs = 8'h00 - sum;
    if (cs_bad) cs = cs + 8'h01;
    total = n + (c_CS ? 1 : 0);
    @(posedge clk); #1 s_start[d] = 1'b1;
    @(posedge clk); #1 s_start[d] = 1'b0;
    k = 0; gap = 0; budget = 400;
    while (k < total && budget > 0) begin
      v = (gap == 0) && (!rnd || ($urandom_range(3) != 0));
      s_valid[d] = v;
      s_data[d]  = v ? ((k < n) ? prog[k] : cs) : 8'($urandom);
      if (rnd) s_start[d] = ($urandom_range(5) == 0);
      if (gap > 0) gap--;
      @(negedge clk);
      if (v && o_in_ready[d] === 1'b1) begin
        k++;
        last_beat = cyc;
        if (k == gap_at) gap = gap_len;
      end
      @(posedge clk); #1;
      budget--;
      if (abort_at != 0 && k == abort_at) break;
    end
    s_valid[d] = 1'b0;
    s_start[d] = 1'b0;
    check("beats_accepted", d, k, (abort_at != 0) ? abort_at : total);
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int dn;
    bit bad;
    logic [7:0] exp_a [4];
    s_data[0] = 8'h00; s_data[1] = 8'h00;
    done_cnt[0] = 0; done_cnt[1] = 0; done_cyc[0] = 0; done_cyc[1] = 0;
    #2 reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_reset", 0, o_cpu_reset[0], 1'b0);
    check("rst_we", 0, o_we[0], 1'b0);
    check("rst_busy", 1, o_busy[1], 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("cpu_reset_release_cycle", 0, o_cpu_reset[0], 1'b0);
    @(negedge clk);
    check("cpu_reset_after_edge", 0, o_cpu_reset[0], 1'b1);

    // Back-to-back 0x10..0x1F
    prog.delete();
    for (int i = 0; i < 16; i++) prog.push_back(8'(8'h10 + i));
    wq0.delete(); dn = done_cnt[0];
    run_load(0, 0, 0, 1'b0, 1'b0, 0);
    settle();
    check("t1_done_count", 0, done_cnt[0] - dn, 1);
    check("t1_done_latency", 0, done_cyc[0] - last_beat, 3);
    check("t1_ram_adr0", 0, ram[0][0], 8'h10);
    check("t1_ram_adr15", 0, ram[0][15], 8'h1F);
    check("t1_nwrites", 0, wq0.size(), 16);
    for (int i = 0; i < 16 && i < wq0.size(); i++) check("t1_addr", 0, wq0[i], i);

    // Same load with a 5-cycle valid gap after byte 3
    for (int i = 0; i < 16; i++) ram[0][i] = 8'h00;
    wq0.delete(); dn = done_cnt[0];
    run_load(0, 4, 5, 1'b0, 1'b0, 0);
    settle();
    check("t2_done_count", 0, done_cnt[0] - dn, 1);
    for (int i = 0; i < 16; i++) check("t2_ram", 0, ram[0][i], 8'(8'h10 + i));
    for (int i = 0; i < 16 && i < wq0.size(); i++) check("t2_addr", 0, wq0[i], i);

    // Sixteen 0x01 bytes (checksum 0xF0 passes, 0xF1 fails)
    prog.delete();
    for (int i = 0; i < 16; i++) prog.push_back(8'h01);
    dn = done_cnt[0];
    run_load(0, 0, 0, 1'b0, 1'b0, 0);
    settle();
    check("t3_done", 0, done_cnt[0] - dn, 1);
    check("t3_err", 0, o_err[0], 1'b0);
    check("t3_cpu_reset", 0, o_cpu_reset[0], 1'b1);
`ifdef LOADER_CHECKSUM_EN
    dn = done_cnt[0];
    run_load(0, 0, 0, 1'b0, 1'b1, 0);
    settle();
    check("t3_bad_no_done", 0, done_cnt[0] - dn, 0);
    check("t3_bad_err", 0, o_err[0], 1'b1);
    check("t3_bad_cpu_reset", 0, o_cpu_reset[0], 1'b0);
`endif

    // Wrap-around on the BASE_ADDR=0xFE, PROG_LEN=4 instance
    prog.delete();
    for (int i = 0; i < 4; i++) prog.push_back(8'(8'hA0 + i));
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    wq1.delete(); dn = done_cnt[1];
    run_load(1, 0, 0, 1'b0, 1'b0, 0);
    settle();
    check("t4_done", 1, done_cnt[1] - dn, 1);
    check("t4_nwrites", 1, wq1.size(), 4);
    for (int i = 0; i < 4 && i < wq1.size(); i++) check("t4_addr", 1, wq1[i], exp_a[i]);
    check("t4_ram_00", 1, ram[1][8'h00], 8'hA2);

    // Reset mid-load after byte 7, then a fresh full load
    prog.delete();
    for (int i = 0; i < 16; i++) prog.push_back(8'(8'h40 + i));
    run_load(0, 0, 0, 1'b0, 1'b0, 8);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    prog.delete();
    for (int i = 0; i < 16; i++) prog.push_back(8'(8'h50 + i));
    wq0.delete(); dn = done_cnt[0];
    run_load(0, 0, 0, 1'b0, 1'b0, 0);
    settle();
    check("t5_done", 0, done_cnt[0] - dn, 1);
    check("t5_nwrites", 0, wq0.size(), 16);
    if (wq0.size() > 0) check("t5_first_addr", 0, wq0[0], c_BASE0);
    check("t5_ram7", 0, ram[0][7], 8'h57);

    // Random loads with stalls, stray starts and random checksum quality
    for (int it = 0; it < 8; it++) begin
      int d, len, base;
      d = it % 2;
      len  = (d == 0) ? c_LEN0 : c_LEN1;
      base = (d == 0) ? int'(c_BASE0) : int'(c_BASE1);
      prog.delete();
      for (int i = 0; i < len; i++) prog.push_back(8'($urandom));
      bad = c_CS && ($urandom_range(1) == 1);
      dn = done_cnt[d];
      run_load(d, 0, 0, 1'b1, bad, 0);
      settle();
      check("rnd_done", d, done_cnt[d] - dn, bad ? 0 : 1);
      for (int j = 0; j < len; j++) check("rnd_ram", d, ram[d][8'((base + j) % 256)], prog[j]);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
